// File: rtl/mem_decoder.sv
// mem_decoder: single-master to NSLV-slave memory decoder with response routing.
//
// Decodes the master request address against per-slave [base, top) windows,
// forwards the request to the selected slave with a rebased address, tracks the
// single outstanding transaction and returns only the selected slave's response.
// Unmapped addresses get a one-cycle error response.
//
// Optional feature (macro MEM_DECODER_TIMEOUT_EN): a busy-cycle counter turns a
// slave that never answers into an error response after TIMEOUT+1 cycles.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   mem_valid/instr/addr/wdata/wstrb   request from master
//   mem_rdata/ready/error              response to master (rdata is 0 unless ready)
//   slv_valid[NSLV]                    per-slave request strobe
//   slv_instr/addr/wdata/wstrb         broadcast request fields (addr rebased)
//   slv_rdata[NSLV*32], slv_ready[NSLV] per-slave response

module mem_decoder #(
    parameter int unsigned        NSLV      = 4,
    parameter logic [NSLV*32-1:0] BASE_ADDR = {NSLV{32'h0}},
    parameter logic [NSLV*32-1:0] TOP_ADDR  = {NSLV{32'h0}},
    parameter int unsigned        TIMEOUT   = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              mem_error,
    output logic [NSLV-1:0]   slv_valid,
    output logic              slv_instr,
    output logic [31:0]       slv_addr,
    output logic [31:0]       slv_wdata,
    output logic [3:0]        slv_wstrb,
    input  logic [NSLV*32-1:0] slv_rdata,
    input  logic [NSLV-1:0]   slv_ready
);

    localparam int unsigned SelW = (NSLV > 1) ? $clog2(NSLV) : 1;

    if (NSLV < 1 || NSLV > 16 || TIMEOUT < 1) begin : gen_param_check
        $error("mem_decoder: NSLV must be 1..16 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;

    state_e          state_q, state_d;
    logic [SelW-1:0] sel_q, sel_d;

    logic            dec_hit;
    logic [SelW-1:0] dec_sel;
    logic [31:0]     dec_base;

    logic [SelW-1:0] route_sel;
    logic            route_ready;
    logic [31:0]     route_rdata;

`ifdef MEM_DECODER_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    // Walk from the highest index down so the lowest matching slave wins.
    always_comb begin
        dec_hit  = 1'b0;
        dec_sel  = '0;
        dec_base = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (mem_addr >= BASE_ADDR[i*32 +: 32] && mem_addr < TOP_ADDR[i*32 +: 32]) begin
                dec_hit  = 1'b1;
                dec_sel  = SelW'(i);
                dec_base = BASE_ADDR[i*32 +: 32];
            end
        end
    end

    assign slv_addr  = dec_hit ? (mem_addr - dec_base) : mem_addr;
    assign slv_instr = mem_instr;
    assign slv_wdata = mem_wdata;
    assign slv_wstrb = mem_wstrb;

    // In IDLE the live decode selects the responder (zero-latency slaves);
    // otherwise only the registered selection may answer.
    assign route_sel = (state_q == StIdle) ? dec_sel : sel_q;

    always_comb begin
        route_ready = 1'b0;
        route_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (SelW'(i) == route_sel) begin
                route_ready = slv_ready[i];
                route_rdata = slv_rdata[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
`ifdef MEM_DECODER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        slv_valid = '0;
        mem_ready = 1'b0;
        mem_error = 1'b0;
        mem_rdata = '0;

        // Outputs held at their reset values while reset is asserted.
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (mem_valid) begin
                        if (dec_hit) begin
                            slv_valid = NSLV'(1) << dec_sel;
                            sel_d     = dec_sel;
`ifdef MEM_DECODER_TIMEOUT_EN
                            cnt_d     = '0;
`endif
                            if (route_ready) begin
                                mem_ready = 1'b1;
                                mem_rdata = route_rdata;
                            end else begin
                                state_d = StBusy;
                            end
                        end else begin
                            state_d = StErr;
                        end
                    end
                end
                StBusy: begin
                    if (route_ready) begin
                        mem_ready = 1'b1;
                        mem_rdata = route_rdata;
                        state_d   = StIdle;
                    end
`ifdef MEM_DECODER_TIMEOUT_EN
                    else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        state_d = StErr;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                StErr: begin
                    mem_ready = 1'b1;
                    mem_error = 1'b1;
                    state_d   = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            sel_q   <= '0;
`ifdef MEM_DECODER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
`ifdef MEM_DECODER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_decoder.sv
// Directed self-checking bench for mem_decoder with the four-slave SoC map.
module tb_mem_decoder;

    localparam int unsigned NSLV = 4;
    localparam logic [NSLV*32-1:0] BASE =
        {32'h8000_0000, 32'h0100_0000, 32'h0200_0000, 32'h0000_0000};
    localparam logic [NSLV*32-1:0] TOP =
        {32'h8010_0000, 32'h0100_0004, 32'h0200_C000, 32'h0010_0000};
`ifdef MEM_DECODER_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 1024;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              mem_valid, mem_instr;
    logic [31:0]       mem_addr, mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;
    logic              mem_ready, mem_error;
    logic [NSLV-1:0]   slv_valid;
    logic              slv_instr;
    logic [31:0]       slv_addr, slv_wdata;
    logic [3:0]        slv_wstrb;
    logic [NSLV*32-1:0] slv_rdata;
    logic [NSLV-1:0]   slv_ready;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_decoder #(
        .NSLV     (NSLV),
        .BASE_ADDR(BASE),
        .TOP_ADDR (TOP),
        .TIMEOUT  (TMO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .mem_error(mem_error),
        .slv_valid(slv_valid),
        .slv_instr(slv_instr),
        .slv_addr (slv_addr),
        .slv_wdata(slv_wdata),
        .slv_wstrb(slv_wstrb),
        .slv_rdata(slv_rdata),
        .slv_ready(slv_ready)
    );

    always #5 clock = ~clock;

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        slv_ready = '0;
        slv_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        mem_valid = 1'b1;
        mem_addr  = 32'h8000_0010;
        slv_ready = 4'b1000;
        slv_rdata[3*32 +: 32] = 32'h1111_2222;
        #3;
        total_cnt++; if (slv_valid !== 4'b0000) $display("FAIL rst_slv_valid got %b exp 0000", slv_valid); else pass_cnt++;
        total_cnt++; if (mem_ready !== 1'b0) $display("FAIL rst_mem_ready got %b exp 0", mem_ready); else pass_cnt++;
        total_cnt++; if (mem_rdata !== 32'h0) $display("FAIL rst_mem_rdata got %h exp 0", mem_rdata); else pass_cnt++;
        total_cnt++; if (mem_error !== 1'b0) $display("FAIL rst_mem_error got %b exp 0", mem_error); else pass_cnt++;
        cyc();
        reset = 1'b0;
        idle_inputs();
        #3;
        total_cnt++; if (mem_ready !== 1'b0) $display("FAIL rst_idle_ready got %b exp 0", mem_ready); else pass_cnt++;
    endtask

    task automatic test_read_delayed();
        mem_valid = 1'b1;
        mem_instr = 1'b1;
        mem_addr  = 32'h8000_0010;
        #3;
        total_cnt++; if (slv_valid !== 4'b1000) $display("FAIL rd_slv_valid got %b exp 1000", slv_valid); else pass_cnt++;
        total_cnt++; if (slv_addr !== 32'h10) $display("FAIL rd_slv_addr got %h exp 00000010", slv_addr); else pass_cnt++;
        total_cnt++; if (slv_instr !== 1'b1) $display("FAIL rd_slv_instr got %b exp 1", slv_instr); else pass_cnt++;
        total_cnt++; if (mem_ready !== 1'b0) $display("FAIL rd_ready_c0 got %b exp 0", mem_ready); else pass_cnt++;
        cyc();
        idle_inputs();
        #3;
        total_cnt++; if (slv_valid !== 4'b0000) $display("FAIL rd_valid_c1 got %b exp 0000", slv_valid); else pass_cnt++;
        total_cnt++; if (mem_ready !== 1'b0) $display("FAIL rd_ready_c1 got %b exp 0", mem_ready); else pass_cnt++;
        cyc();
        slv_ready = 4'b1000;
        slv_rdata[3*32 +: 32] = 32'hDEAD_BEEF;
        #3;
        total_cnt++; if (mem_ready !== 1'b1) $display("FAIL rd_ready_c2 got %b exp 1", mem_ready); else pass_cnt++;
        total_cnt++; if (mem_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rdata got %h exp deadbeef", mem_rdata); else pass_cnt++;
        total_cnt++; if (mem_error !== 1'b0) $display("FAIL rd_error got %b exp 0", mem_error); else pass_cnt++;
        cyc();
        idle_inputs();
        #3;
        total_cnt++; if (mem_ready !== 1'b0) $display("FAIL rd_ready_after got %b exp 0", mem_ready); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        mem_valid = 1'b1;
        mem_addr  = 32'h0100_0000;
        mem_wdata = 32'h41;
        mem_wstrb = 4'b0001;
        slv_ready = 4'b0100;
        slv_rdata[2*32 +: 32] = 32'h0000_0055;
        #3;
        total_cnt++; if (slv_valid !== 4'b0100) $display("FAIL zl_slv_valid got %b exp 0100", slv_valid); else pass_cnt++;
        total_cnt++; if (slv_addr !== 32'h0) $display("FAIL zl_slv_addr got %h exp 0", slv_addr); else pass_cnt++;
        total_cnt++; if (slv_wdata !== 32'h41 || slv_wstrb !== 4'b0001) $display("FAIL zl_bcast got %h/%b exp 41/0001", slv_wdata, slv_wstrb); else pass_cnt++;
        total_cnt++; if (mem_ready !== 1'b1) $display("FAIL zl_ready got %b exp 1", mem_ready); else pass_cnt++;
        total_cnt++; if (mem_rdata !== 32'h55) $display("FAIL zl_rdata got %h exp 55", mem_rdata); else pass_cnt++;
        total_cnt++; if (mem_error !== 1'b0) $display("FAIL zl_error got %b exp 0", mem_error); else pass_cnt++;
        cyc();
        idle_inputs();
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0020;
        #3;
        total_cnt++; if (slv_valid !== 4'b0001) $display("FAIL b2b_slv_valid got %b exp 0001", slv_valid); else pass_cnt++;
        total_cnt++; if (slv_addr !== 32'h20) $display("FAIL b2b_slv_addr got %h exp 20", slv_addr); else pass_cnt++;
        cyc();
        idle_inputs();
        slv_ready = 4'b0001;
        slv_rdata[0 +: 32] = 32'h0000_0077;
        #3;
        total_cnt++; if (mem_ready !== 1'b1 || mem_rdata !== 32'h77) $display("FAIL b2b_resp got %b/%h exp 1/77", mem_ready, mem_rdata); else pass_cnt++;
        cyc();
        idle_inputs();
    endtask

    task automatic test_boundary();
        // Last word of slave 1, answered in the same cycle.
        mem_valid = 1'b1;
        mem_addr  = 32'h0200_BFFC;
        slv_ready = 4'b0010;
        slv_rdata[1*32 +: 32] = 32'hA5A5_0001;
        #3;
        total_cnt++; if (slv_valid !== 4'b0010) $display("FAIL bnd_hi_valid got %b exp 0010", slv_valid); else pass_cnt++;
        total_cnt++; if (slv_addr !== 32'h0000_BFFC) $display("FAIL bnd_hi_addr got %h exp 0000bffc", slv_addr); else pass_cnt++;
        cyc();
        idle_inputs();
        // Exclusive top of slave 2 is unmapped; address passes through unchanged.
        mem_valid = 1'b1;
        mem_addr  = 32'h0100_0004;
        #3;
        total_cnt++; if (slv_valid !== 4'b0000) $display("FAIL bnd_top_valid got %b exp 0000", slv_valid); else pass_cnt++;
        total_cnt++; if (slv_addr !== 32'h0100_0004) $display("FAIL bnd_top_addr got %h exp 01000004", slv_addr); else pass_cnt++;
        cyc();
        idle_inputs();
        #3;
        total_cnt++; if (mem_ready !== 1'b1 || mem_error !== 1'b1) $display("FAIL bnd_top_err got %b/%b exp 1/1", mem_ready, mem_error); else pass_cnt++;
        cyc();
    endtask

    task automatic test_unmapped();
        mem_valid = 1'b1;
        mem_addr  = 32'h4000_0000;
        #3;
        total_cnt++; if (slv_valid !== 4'b0000) $display("FAIL um_slv_valid got %b exp 0000", slv_valid); else pass_cnt++;
        total_cnt++; if (mem_ready !== 1'b0) $display("FAIL um_ready_c0 got %b exp 0", mem_ready); else pass_cnt++;
        cyc();
        idle_inputs();
        slv_ready = 4'b1111;
        slv_rdata = {NSLV{32'hFFFF_FFFF}};
        #3;
        total_cnt++; if (mem_ready !== 1'b1) $display("FAIL um_ready got %b exp 1", mem_ready); else pass_cnt++;
        total_cnt++; if (mem_error !== 1'b1) $display("FAIL um_error got %b exp 1", mem_error); else pass_cnt++;
        total_cnt++; if (mem_rdata !== 32'h0) $display("FAIL um_rdata got %h exp 0", mem_rdata); else pass_cnt++;
        cyc();
        idle_inputs();
        #3;
        total_cnt++; if (mem_ready !== 1'b0 || mem_error !== 1'b0) $display("FAIL um_after got %b/%b exp 0/0", mem_ready, mem_error); else pass_cnt++;
    endtask

    task automatic test_wrong_slave();
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0100;
        cyc();
        idle_inputs();
        // Stray request while busy plus a response from the wrong slave.
        mem_valid = 1'b1;
        mem_addr  = 32'h8000_0000;
        slv_ready = 4'b0010;
        slv_rdata[1*32 +: 32] = 32'h0000_1234;
        #3;
        total_cnt++; if (slv_valid !== 4'b0000) $display("FAIL ws_stray_valid got %b exp 0000", slv_valid); else pass_cnt++;
        total_cnt++; if (mem_ready !== 1'b0) $display("FAIL ws_ready_c1 got %b exp 0", mem_ready); else pass_cnt++;
        total_cnt++; if (mem_rdata !== 32'h0) $display("FAIL ws_rdata_c1 got %h exp 0", mem_rdata); else pass_cnt++;
        cyc();
        idle_inputs();
        slv_rdata[1*32 +: 32] = 32'h0000_1234;
        #3;
        total_cnt++; if (mem_ready !== 1'b0) $display("FAIL ws_ready_c2 got %b exp 0", mem_ready); else pass_cnt++;
        cyc();
        slv_ready = 4'b0011;
        slv_rdata[0 +: 32] = 32'h0000_CAFE;
        #3;
        total_cnt++; if (mem_ready !== 1'b1 || mem_rdata !== 32'hCAFE) $display("FAIL ws_resp got %b/%h exp 1/0000cafe", mem_ready, mem_rdata); else pass_cnt++;
        cyc();
        idle_inputs();
    endtask

`ifdef MEM_DECODER_TIMEOUT_EN
    task automatic test_timeout();
        int early_ready;
        early_ready = 0;
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0000;
        cyc();
        idle_inputs();
        for (int c = 1; c <= 8; c++) begin
            #3;
            if (mem_ready !== 1'b0) early_ready++;
            cyc();
        end
        total_cnt++; if (early_ready != 0) $display("FAIL to_early got %0d ready cycles exp 0", early_ready); else pass_cnt++;
        #3;
        total_cnt++; if (mem_ready !== 1'b1 || mem_error !== 1'b1) $display("FAIL to_err_c9 got %b/%b exp 1/1", mem_ready, mem_error); else pass_cnt++;
        cyc();
        cyc();
        cyc();
        slv_ready = 4'b0001;
        slv_rdata[0 +: 32] = 32'h0BAD_0BAD;
        #3;
        total_cnt++; if (mem_ready !== 1'b0) $display("FAIL to_late_c12 got %b exp 0", mem_ready); else pass_cnt++;
        cyc();
        idle_inputs();
        // Ready on the limit cycle beats the timeout.
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0004;
        cyc();
        idle_inputs();
        for (int c = 1; c < 8; c++) cyc();
        slv_ready = 4'b0001;
        slv_rdata[0 +: 32] = 32'h0000_0088;
        #3;
        total_cnt++; if (mem_ready !== 1'b1 || mem_error !== 1'b0 || mem_rdata !== 32'h88) $display("FAIL to_limit got %b/%b/%h exp 1/0/88", mem_ready, mem_error, mem_rdata); else pass_cnt++;
        cyc();
        idle_inputs();
    endtask
`else
    task automatic test_no_timeout();
        int early_ready;
        early_ready = 0;
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0000;
        cyc();
        idle_inputs();
        for (int c = 1; c <= 20; c++) begin
            #3;
            if (mem_ready !== 1'b0) early_ready++;
            cyc();
        end
        total_cnt++; if (early_ready != 0) $display("FAIL nto_wait got %0d ready cycles exp 0", early_ready); else pass_cnt++;
        slv_ready = 4'b0001;
        slv_rdata[0 +: 32] = 32'h0000_0099;
        #3;
        total_cnt++; if (mem_ready !== 1'b1 || mem_error !== 1'b0 || mem_rdata !== 32'h99) $display("FAIL nto_resp got %b/%b/%h exp 1/0/99", mem_ready, mem_error, mem_rdata); else pass_cnt++;
        cyc();
        idle_inputs();
    endtask
`endif

    task automatic test_reset_mid();
        mem_valid = 1'b1;
        mem_addr  = 32'h8000_0000;
        cyc();
        idle_inputs();
        cyc();
        reset = 1'b1;
        #3;
        total_cnt++; if (mem_ready !== 1'b0 || slv_valid !== 4'b0000) $display("FAIL rm_during got %b/%b exp 0/0000", mem_ready, slv_valid); else pass_cnt++;
        cyc();
        reset = 1'b0;
        slv_ready = 4'b1000;
        slv_rdata[3*32 +: 32] = 32'h0000_0BAD;
        #3;
        total_cnt++; if (mem_ready !== 1'b0) $display("FAIL rm_late_ready got %b exp 0", mem_ready); else pass_cnt++;
        total_cnt++; if (mem_rdata !== 32'h0) $display("FAIL rm_late_rdata got %h exp 0", mem_rdata); else pass_cnt++;
        cyc();
        #3;
        total_cnt++; if (mem_ready !== 1'b0) $display("FAIL rm_late_ready2 got %b exp 0", mem_ready); else pass_cnt++;
        cyc();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_read_delayed();
        test_back_to_back();
        test_boundary();
        test_unmapped();
        test_wrong_slave();
`ifdef MEM_DECODER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
